// File: rtl/tdm_demux.sv
// ----------------------------------------------------------------------------
// tdm_demux
//   Receive side of the round-robin TDM path. Splits one time-multiplexed word
//   stream (channel 0 marked by in_sof) back into NCH registered per-channel
//   words with one-cycle strobes. A two-state sync FSM (HUNT/LOCK) tracks
//   frame alignment and pulses sync_err on a misplaced or missing SOF.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   in_valid    in_data/in_sof valid this cycle
//   in_sof      this beat carries channel 0
//   in_data     multiplexed word (W bits)
//   ch_data     channel k word at [k*W +: W], holds last written value
//   ch_valid    one-cycle strobe per channel, at most one bit set
//   frame_done  one-cycle pulse when channel NCH-1 is written
//   sync_err    one-cycle pulse on early or missing SOF
//   locked      high while the FSM is in LOCK
// ----------------------------------------------------------------------------
module tdm_demux #(
    parameter int NCH = 4,
    parameter int W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [W-1:0]     in_data,
    output logic [NCH*W-1:0] ch_data,
    output logic [NCH-1:0]   ch_valid,
    output logic             frame_done,
    output logic             sync_err,
    output logic             locked
);

    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(NCH - 1);
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);

    typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [NCH*W-1:0]  data_q, data_d;
    logic [NCH-1:0]    valid_q, valid_d;
    logic              fdone_q, fdone_d;
    logic              serr_q, serr_d;

    // Write request from the FSM; applied to the data/strobe next-state below.
    logic              wr_en;
    logic [SW-1:0]     wr_idx;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        fdone_d = 1'b0;
        serr_d  = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = '0;

        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    // Words before the first SOF are dropped silently.
                    if (in_sof) begin
                        wr_en   = 1'b1;
                        slot_d  = SLOT_ONE;
                        state_d = LOCK;
                    end
                end
                LOCK: begin
                    if (in_sof) begin
                        // SOF mid-frame abandons the partial frame but is
                        // trusted as the new frame start.
                        serr_d = (slot_q != '0);
                        wr_en  = 1'b1;
                        slot_d = SLOT_ONE;
                    end else if (slot_q == '0) begin
                        // Expected SOF never came: alignment lost.
                        serr_d  = 1'b1;
                        slot_d  = '0;
                        state_d = HUNT;
                    end else begin
                        wr_en   = 1'b1;
                        wr_idx  = slot_q;
                        fdone_d = (slot_q == SLOT_LAST);
                        slot_d  = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_ONE;
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = '0;
        if (wr_en) begin
            data_d[wr_idx*W +: W] = in_data;
            valid_d[wr_idx]       = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            slot_q  <= '0;
            data_q  <= '0;
            valid_q <= '0;
            fdone_q <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fdone_q <= fdone_d;
            serr_q  <= serr_d;
        end
    end

    assign ch_data    = data_q;
    assign ch_valid   = valid_q;
    assign frame_done = fdone_q;
    assign sync_err   = serr_q;
    assign locked     = (state_q == LOCK);

endmodule
